// File: rtl/i2c_pad_pkg.sv
// Shared constants for the I2C pad conditioner: event bit positions inside each channel's
// {arb, stop, start} field and the default parameter values.
package i2c_pad_pkg;
    localparam int EVT_START = 0;
    localparam int EVT_STOP  = 1;
    localparam int EVT_ARB   = 2;
    localparam int EVT_NUM   = 3;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_FILT_W      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_IDLE_CYC    = 1024;
endpackage

// File: rtl/i2c_glitch_filt.sv
// One-bit pad synchroniser plus counter glitch filter; idles high.
// Latency SYNC_STAGES + thr + 1 cycles; no backpressure, continuous sampling.
// A level must persist for thr+1 synced cycles before the filtered output follows it.
module i2c_glitch_filt
    import i2c_pad_pkg::*;
#(
    parameter int FILT_W      = DEF_FILT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FILT_W-1:0] thr,
    input  logic              din,
    output logic              dout
);
    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_W-1:0]      cnt;
    logic                   filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (sync[SYNC_STAGES-1] == filt) begin
                cnt <= '0;
            end else if (cnt == thr) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + FILT_W'(1);
            end
        end
    end

    assign dout = filt;
endmodule

// File: rtl/i2c_pad_ctrl.sv
// Multi-channel I2C pad conditioner: open-drain drive, filtering, START/STOP, busy, arb, stretch, irq.
// Latency: drive 1 cycle; pad to filtered level SYNC_STAGES+thr+1, events one cycle later.
// No backpressure: pads are sampled every cycle. Optional bus-free timeout under I2C_PAD_IDLE_TO_EN.
module i2c_pad_ctrl
    import i2c_pad_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int FILT_W      = DEF_FILT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int IDLE_CYC    = DEF_IDLE_CYC
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [FILT_W-1:0]         filt_thr_i,
    input  logic [NUM_CH-1:0]         scl_i,
    input  logic [NUM_CH-1:0]         sda_i,
    output logic [NUM_CH-1:0]         scl_o,
    output logic [NUM_CH-1:0]         scl_dir_o,
    output logic [NUM_CH-1:0]         sda_o,
    output logic [NUM_CH-1:0]         sda_dir_o,
    input  logic [NUM_CH-1:0]         scl_pull_i,
    input  logic [NUM_CH-1:0]         sda_pull_i,
    input  logic [NUM_CH-1:0]         master_i,
    output logic [NUM_CH-1:0]         scl_filt_o,
    output logic [NUM_CH-1:0]         sda_filt_o,
    output logic [NUM_CH-1:0]         start_o,
    output logic [NUM_CH-1:0]         stop_o,
    output logic [NUM_CH-1:0]         busy_o,
    output logic [NUM_CH-1:0]         arb_lost_o,
    output logic [NUM_CH-1:0]         stretch_o,
    input  logic [EVT_NUM*NUM_CH-1:0] irq_en_i,
    input  logic [EVT_NUM*NUM_CH-1:0] evt_clr_i,
    output logic [EVT_NUM*NUM_CH-1:0] evt_o,
    output logic [NUM_CH-1:0]         irq_o
);
    // Stretch counter must hold SYNC_STAGES + max threshold + 2.
    localparam int STR_W = $clog2(SYNC_STAGES + 2**FILT_W + 2);

    if (NUM_CH < 1 || NUM_CH > 8 || SYNC_STAGES < 2 || IDLE_CYC < 1) begin : g_param_check
        $error("i2c_pad_ctrl: illegal parameter value");
    end

    logic [STR_W-1:0] str_lim;

    assign scl_o   = '0;
    assign sda_o   = '0;
    // Own release reaches the filtered level after SYNC+thr+1 cycles; one more masks it.
    assign str_lim = STR_W'(SYNC_STAGES) + STR_W'(filt_thr_i) + STR_W'(2);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic               scl_f, sda_f, scl_q, sda_q;
        logic               start_det, stop_det, arb_det, idle_to;
        logic               scl_dir, sda_dir, start_p, stop_p, arb_p, busy, irq;
        logic [EVT_NUM-1:0] evt;
        logic [STR_W-1:0]   str_cnt;

        i2c_glitch_filt #(.FILT_W(FILT_W), .SYNC_STAGES(SYNC_STAGES)) u_scl_filt (
            .clk(clk_i), .rst_n(rst_n_i), .thr(filt_thr_i), .din(scl_i[c]), .dout(scl_f)
        );
        i2c_glitch_filt #(.FILT_W(FILT_W), .SYNC_STAGES(SYNC_STAGES)) u_sda_filt (
            .clk(clk_i), .rst_n(rst_n_i), .thr(filt_thr_i), .din(sda_i[c]), .dout(sda_f)
        );

        // SCL must be high in both cycles, so simultaneous SCL/SDA changes never qualify.
        assign start_det = scl_q & scl_f & sda_q & ~sda_f;
        assign stop_det  = scl_q & scl_f & ~sda_q & sda_f;
        assign arb_det   = master_i[c] & ~sda_pull_i[c]
                         & ((~scl_q & scl_f & ~sda_f) | stop_det);

`ifdef I2C_PAD_IDLE_TO_EN
        localparam int IDLE_W = $clog2(IDLE_CYC + 1);
        logic [IDLE_W-1:0] idle_cnt;
        logic              idle_run;

        assign idle_run = busy & scl_f & sda_f;
        assign idle_to  = idle_run & (idle_cnt == IDLE_W'(IDLE_CYC - 1));

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                idle_cnt <= '0;
            end else if (!idle_run || idle_to) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
`else
        assign idle_to = 1'b0;
`endif

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
                scl_dir <= 1'b0;
                sda_dir <= 1'b0;
                start_p <= 1'b0;
                stop_p  <= 1'b0;
                arb_p   <= 1'b0;
                busy    <= 1'b0;
                evt     <= '0;
                irq     <= 1'b0;
                str_cnt <= '0;
            end else begin
                scl_q   <= scl_f;
                sda_q   <= sda_f;
                scl_dir <= scl_pull_i[c];
                sda_dir <= sda_pull_i[c];
                start_p <= start_det;
                stop_p  <= stop_det;
                arb_p   <= arb_det;
                if (start_det) begin
                    busy <= 1'b1;
                end else if (stop_det || idle_to) begin
                    busy <= 1'b0;
                end
                // Set wins over a coincident clear.
                evt <= (evt & ~evt_clr_i[EVT_NUM*c +: EVT_NUM]) | {arb_p, stop_p, start_p};
                irq <= |(evt & irq_en_i[EVT_NUM*c +: EVT_NUM]);
                if (scl_pull_i[c] || scl_f) begin
                    str_cnt <= '0;
                end else if (str_cnt < str_lim) begin
                    str_cnt <= str_cnt + STR_W'(1);
                end
            end
        end

        assign scl_dir_o[c]                   = scl_dir;
        assign sda_dir_o[c]                   = sda_dir;
        assign scl_filt_o[c]                  = scl_f;
        assign sda_filt_o[c]                  = sda_f;
        assign start_o[c]                     = start_p;
        assign stop_o[c]                      = stop_p;
        assign arb_lost_o[c]                  = arb_p;
        assign busy_o[c]                      = busy;
        assign stretch_o[c]                   = (str_cnt >= str_lim);
        assign evt_o[EVT_NUM*c +: EVT_NUM]    = evt;
        assign irq_o[c]                       = irq;
    end
endmodule

// File: tb/tb_i2c_pad_ctrl.sv
// Bench for i2c_pad_ctrl: behavioural model compared every cycle plus directed literal checks.
// Honours I2C_PAD_IDLE_TO_EN for the bus-free timeout scenario.
module tb_i2c_pad_ctrl;
    localparam int NUM_CH = 2;
    localparam int FILT_W = 4;
    localparam int SYNC   = 2;
    localparam int IDLE   = 16;
    localparam int HW     = 2**FILT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [FILT_W-1:0] thr;
    logic [NUM_CH-1:0] scl_i, sda_i, scl_pull, sda_pull, master;
    logic [3*NUM_CH-1:0] irq_en, evt_clr;
    logic [NUM_CH-1:0] scl_o, sda_o, scl_dir_o, sda_dir_o, scl_filt_o, sda_filt_o;
    logic [NUM_CH-1:0] start_o, stop_o, busy_o, arb_lost_o, stretch_o, irq_o;
    logic [3*NUM_CH-1:0] evt_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int n_start[NUM_CH], n_stop[NUM_CH], n_arb[NUM_CH];

    // Model state: index [ch][0]=SCL, [ch][1]=SDA.
    logic [SYNC-1:0] m_sh[NUM_CH][2];
    logic [HW-1:0]   m_hist[NUM_CH][2];
    logic            m_filt[NUM_CH][2];
    logic            m_prev[NUM_CH][2];
    logic            m_start[NUM_CH], m_stop[NUM_CH], m_arb[NUM_CH], m_busy[NUM_CH];
    logic            m_irq[NUM_CH], m_sdir[NUM_CH], m_ddir[NUM_CH];
    logic [2:0]      m_evt[NUM_CH];
    int              m_run[NUM_CH], m_idle[NUM_CH];

    always #5 clk = ~clk;

    i2c_pad_ctrl #(.NUM_CH(NUM_CH), .FILT_W(FILT_W), .SYNC_STAGES(SYNC), .IDLE_CYC(IDLE)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .filt_thr_i(thr), .scl_i(scl_i), .sda_i(sda_i),
        .scl_o(scl_o), .scl_dir_o(scl_dir_o), .sda_o(sda_o), .sda_dir_o(sda_dir_o),
        .scl_pull_i(scl_pull), .sda_pull_i(sda_pull), .master_i(master),
        .scl_filt_o(scl_filt_o), .sda_filt_o(sda_filt_o), .start_o(start_o), .stop_o(stop_o),
        .busy_o(busy_o), .arb_lost_o(arb_lost_o), .stretch_o(stretch_o),
        .irq_en_i(irq_en), .evt_clr_i(evt_clr), .evt_o(evt_o), .irq_o(irq_o)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A level is accepted once the newest thr+1 synced samples all differ from the filtered one.
    function automatic logic win(logic [HW-1:0] h, logic f, logic [FILT_W-1:0] t);
        for (int k = 0; k < HW; k++)
            if (k <= int'(t) && h[k] == f) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic f_start(int c);
        return m_prev[c][0] & m_filt[c][0] & m_prev[c][1] & ~m_filt[c][1];
    endfunction

    function automatic logic f_stop(int c);
        return m_prev[c][0] & m_filt[c][0] & ~m_prev[c][1] & m_filt[c][1];
    endfunction

    function automatic logic f_idle_hit(int c);
`ifdef I2C_PAD_IDLE_TO_EN
        return m_busy[c] & m_filt[c][0] & m_filt[c][1] & (m_idle[c] + 1 >= IDLE);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int l = 0; l < 2; l++) begin
                    m_sh[c][l] <= '1; m_hist[c][l] <= '1; m_filt[c][l] <= 1'b1; m_prev[c][l] <= 1'b1;
                end
                m_start[c] <= 0; m_stop[c] <= 0; m_arb[c] <= 0; m_busy[c] <= 0;
                m_irq[c] <= 0; m_sdir[c] <= 0; m_ddir[c] <= 0; m_evt[c] <= '0;
                m_run[c] <= 0; m_idle[c] <= 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_sdir[c]  <= scl_pull[c];
                m_ddir[c]  <= sda_pull[c];
                m_start[c] <= f_start(c);
                m_stop[c]  <= f_stop(c);
                m_arb[c]   <= master[c] & ~sda_pull[c] &
                              ((~m_prev[c][0] & m_filt[c][0] & ~m_filt[c][1]) | f_stop(c));
                m_irq[c]   <= |(m_evt[c] & irq_en[3*c +: 3]);
                m_evt[c]   <= (m_evt[c] & ~evt_clr[3*c +: 3]) | {m_arb[c], m_stop[c], m_start[c]};
                m_run[c]   <= (!scl_pull[c] && !m_filt[c][0]) ? m_run[c] + 1 : 0;
                if (f_start(c)) m_busy[c] <= 1'b1;
                else if (f_stop(c) || f_idle_hit(c)) m_busy[c] <= 1'b0;
                if (m_busy[c] && m_filt[c][0] && m_filt[c][1] && !f_idle_hit(c)) m_idle[c] <= m_idle[c] + 1;
                else m_idle[c] <= 0;
                for (int l = 0; l < 2; l++) begin
                    m_hist[c][l] <= {m_hist[c][l][HW-2:0], m_sh[c][l][SYNC-1]};
                    if (win({m_hist[c][l][HW-2:0], m_sh[c][l][SYNC-1]}, m_filt[c][l], thr))
                        m_filt[c][l] <= ~m_filt[c][l];
                    m_prev[c][l] <= m_filt[c][l];
                    m_sh[c][l]   <= {m_sh[c][l][SYNC-2:0], (l == 0) ? scl_i[c] : sda_i[c]};
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NUM_CH-1:0] e_sf, e_df, e_st, e_sp, e_bz, e_ar, e_str, e_irq, e_sd, e_dd;
            logic [3*NUM_CH-1:0] e_evt;
            for (int c = 0; c < NUM_CH; c++) begin
                e_sf[c] = m_filt[c][0]; e_df[c] = m_filt[c][1];
                e_st[c] = m_start[c]; e_sp[c] = m_stop[c]; e_bz[c] = m_busy[c]; e_ar[c] = m_arb[c];
                e_str[c] = (m_run[c] >= SYNC + int'(thr) + 2);
                e_irq[c] = m_irq[c]; e_sd[c] = m_sdir[c]; e_dd[c] = m_ddir[c];
                e_evt[3*c +: 3] = m_evt[c];
                n_start[c] += int'(start_o[c]);
                n_stop[c]  += int'(stop_o[c]);
                n_arb[c]   += int'(arb_lost_o[c]);
            end
            chk("pad_out", 32'({scl_o, sda_o}), 32'h0);
            chk("scl_filt", 32'(scl_filt_o), 32'(e_sf));
            chk("sda_filt", 32'(sda_filt_o), 32'(e_df));
            chk("start", 32'(start_o), 32'(e_st));
            chk("stop", 32'(stop_o), 32'(e_sp));
            chk("busy", 32'(busy_o), 32'(e_bz));
            chk("arb_lost", 32'(arb_lost_o), 32'(e_ar));
            chk("stretch", 32'(stretch_o), 32'(e_str));
            chk("evt", 32'(evt_o), 32'(e_evt));
            chk("irq", 32'(irq_o), 32'(e_irq));
            chk("scl_dir", 32'(scl_dir_o), 32'(e_sd));
            chk("sda_dir", 32'(sda_dir_o), 32'(e_dd));
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int n, s;
        bit found;
        thr = 4'd3; scl_i = '1; sda_i = '1; scl_pull = '0; sda_pull = '0; master = '0;
        irq_en = '0; evt_clr = '0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("rst_filt", 32'({scl_filt_o, sda_filt_o}), 32'hF);
        chk("rst_outs", 32'({busy_o, start_o, stop_o, arb_lost_o, stretch_o, irq_o}), 32'h0);
        chk("rst_evt_dir", 32'({evt_o, scl_dir_o, sda_dir_o}), 32'h0);

        // Glitch filter, thr = 3: 3-cycle low rejected, 4-cycle low accepted after 6 cycles.
        sda_i[0] = 1'b0; step(3); sda_i[0] = 1'b1;
        n = 0;
        repeat (12) begin step(1); if (!sda_filt_o[0]) n++; end
        chk("glitch3_rejected", 32'(n), 32'd0);
        sda_i[0] = 1'b0; step(4); sda_i[0] = 1'b1;
        step(1); chk("glitch4_t5", 32'(sda_filt_o[0]), 32'd1);
        step(1); chk("glitch4_t6", 32'(sda_filt_o[0]), 32'd0);
        step(20);

        // START/STOP on ch1, thr = 0, irq on {stop,start}.
        thr = 4'd0; irq_en = 6'b011_000;
        evt_clr = '1; step(1); evt_clr = '0;
        s = n_start[1];
        sda_i[1] = 1'b0; step(8);
        chk("start_once", 32'(n_start[1] - s), 32'd1);
        chk("busy_set", 32'(busy_o[1]), 32'd1);
        chk("evt_start", 32'(evt_o[3]), 32'd1);
        chk("irq_start", 32'(irq_o[1]), 32'd1);
        s = n_stop[1];
        sda_i[1] = 1'b1; step(8);
        chk("stop_once", 32'(n_stop[1] - s), 32'd1);
        chk("busy_clr", 32'(busy_o[1]), 32'd0);
        chk("evt_stop", 32'(evt_o[4]), 32'd1);
        evt_clr = 6'b111_000; step(1); evt_clr = '0; step(2);
        chk("evt_cleared", 32'(evt_o[5:3]), 32'd0);
        chk("irq_cleared", 32'(irq_o[1]), 32'd0);

        // Arbitration on ch0 with the arb irq masked.
        irq_en = '0;
        evt_clr = '1; step(1); evt_clr = '0;
        scl_i[0] = 1'b0; step(8);
        sda_i[0] = 1'b0; step(8);
        master[0] = 1'b1;
        s = n_arb[0];
        repeat (3) begin
            scl_i[0] = 1'b1; step(6);
            scl_i[0] = 1'b0; step(6);
        end
        chk("arb_three", 32'(n_arb[0] - s), 32'd3);
        chk("evt_arb", 32'(evt_o[2]), 32'd1);
        chk("irq_arb_masked", 32'(irq_o[0]), 32'd0);
        master[0] = 1'b0;
        scl_i[0] = 1'b1; step(6);
        sda_i[0] = 1'b1; step(8);
        chk("no_arb_slave_stop", 32'(n_arb[0] - s), 32'd3);

        // Clock stretch on ch0, thr = 2: limit 6 cycles.
        thr = 4'd2;
        scl_pull[0] = 1'b1; scl_i[0] = 1'b0; step(10);
        scl_pull[0] = 1'b0;
        step(5); chk("stretch_t5", 32'(stretch_o[0]), 32'd0);
        step(1); chk("stretch_t6", 32'(stretch_o[0]), 32'd1);
        step(44);
        scl_i[0] = 1'b1;
        step(5); chk("stretch_hold", 32'(stretch_o[0]), 32'd1);
        step(1); chk("stretch_fall", 32'(stretch_o[0]), 32'd0);
        scl_pull[0] = 1'b1; scl_i[0] = 1'b0; step(10);
        scl_pull[0] = 1'b0; scl_i[0] = 1'b1;
        n = 0;
        repeat (15) begin step(1); if (stretch_o[0]) n++; end
        chk("no_stretch_own", 32'(n), 32'd0);

        // Simultaneous SCL/SDA changes on ch1.
        thr = 4'd0;
        s = n_start[1] + n_stop[1];
        scl_i[1] = 1'b0; sda_i[1] = 1'b0; step(6);
        scl_i[1] = 1'b1; sda_i[1] = 1'b1; step(6);
        chk("simul_no_event", 32'(n_start[1] + n_stop[1] - s), 32'd0);

        // Clear coinciding with the start pulse: set wins.
        evt_clr = '1; step(1); evt_clr = '0;
        sda_i[1] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (start_o[1]) found = 1'b1;
        end
        chk("start_seen", 32'(found), 32'd1);
        evt_clr[3] = 1'b1;
        @(posedge clk); #2;
        evt_clr = '0;
        chk("set_beats_clr", 32'(evt_o[3]), 32'd1);
        sda_i[1] = 1'b1; step(6);

        // Async reset mid-transfer releases both pads at once.
        scl_pull = '1; sda_pull = '1; step(3);
        chk("dir_driven", 32'({scl_dir_o, sda_dir_o}), 32'hF);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_dir_released", 32'({scl_dir_o, sda_dir_o}), 32'h0);
        chk("rst_filt_idle", 32'({scl_filt_o, sda_filt_o}), 32'hF);
        @(posedge clk); #2;
        scl_pull = '0; sda_pull = '0; rst_n = 1'b1;
        step(3);

        // Missed STOP: START, then both lines high without a STOP.
        sda_i[0] = 1'b0; step(6);
        scl_i[0] = 1'b0; step(6);
        sda_i[0] = 1'b1; step(6);
        scl_i[0] = 1'b1;
        s = n_stop[0];
        step(30);
`ifdef I2C_PAD_IDLE_TO_EN
        chk("idle_timeout_busy", 32'(busy_o[0]), 32'd0);
`else
        chk("no_timeout_busy", 32'(busy_o[0]), 32'd1);
`endif
        chk("idle_no_stop", 32'(n_stop[0] - s), 32'd0);

        step(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
